mem_responder: RTL and testbench

Memory-side responder for the core's data/instruction memory port: accepts one word-aligned read or masked write request at a time over a valid/ready handshake, services it from an internal word array after a fixed programmable latency, and returns the result over a second valid/ready handshake. The byte-mask convention matches the `pmem_write` DPI path. This lets the memory initiators run against synthesizable RTL with realistic wait states instead of same-cycle DPI calls.

---
 rtl/mem_responder.sv | 205 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the core's data/instruction memory port. Accepts
// one word-aligned read or byte-masked write at a time over a valid/ready
// request handshake. Services it from an internal word array after a fixed
// number of clock edges (LATENCY). Returns the result over a second
// valid/ready response handshake.
//
// Parameters
//   ADDR_BASE  : byte address of array word 0
//   DEPTH_LOG2 : array holds 2**DEPTH_LOG2 32-bit words (DEPTH_LOG2 <= 29)
//   LATENCY    : edges from request acceptance to resp_valid_o rising (1..15)
//
// Ports
//   clk_i         : single clock, all state changes on posedge
//   rst_i         : asynchronous active-high reset (array contents untouched)
//   req_valid_i   : request present
//   req_ready_o   : responder can accept a request (high only in IDLE)
//   req_addr_i    : byte address, bits [1:0] ignored
//   req_wen_i     : 1 = write, 0 = read
//   req_wdata_i   : write data
//   req_wmask_i   : bit k enables write byte k (k = 0..3), bits [7:4] ignored
//   resp_valid_o  : response present (high only in RESP)
//   resp_ready_i  : initiator takes the response
//   resp_rdata_o  : read word, 0 for writes and errors
//   resp_err_o    : address fell outside the array
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_wen_i,
  input  logic [31:0] req_wdata_i,
  input  logic [7:0]  req_wmask_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int unsigned DEPTH    = 32'd1 << DEPTH_LOG2;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Control state
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Latched request
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;

  // Registered outputs
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Array and access decode
  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           off_s;
  logic                  in_range_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic                  mem_we_s;
  logic                  unused_s;

  // Address decode of the latched request. The subtraction wraps modulo 2^32,
  // so addresses below ADDR_BASE land far above the array and read as out of
  // range.
  always_comb begin
    off_s      = addr_q - ADDR_BASE;
    in_range_s = ((off_s >> (DEPTH_LOG2 + 32'd2)) == 32'd0);
    idx_s      = off_s[DEPTH_LOG2+1:2];
  end

  // Byte-offset bits and the upper mask nibble carry no meaning here.
  assign unused_s = ^{req_wmask_i[7:4], off_s[1:0]};

  // Next-state, request latch and response data selection.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    mem_we_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          wen_d   = req_wen_i;
          wdata_d = req_wdata_i;
          wmask_d = req_wmask_i[3:0];
          cnt_d   = CNT_INIT;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Access edge: the write commit and the resp_valid rise share it,
          // so a read issued after this response sees the new data.
          state_d = ST_RESP;
          if (!in_range_s) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end else if (wen_q) begin
            rdata_d  = 32'd0;
            err_d    = 1'b0;
            mem_we_s = 1'b1;
          end else begin
            rdata_d = mem_q[idx_s];
            err_d   = 1'b0;
          end
        end
      end

      ST_RESP: begin
        // No accept on the handshake edge: IDLE is only entered here.
        if (resp_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Handshake flags are registered decodes of the next state.
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  // Control, latch and output registers; async reset returns to IDLE and
  // abandons any in-flight request without a response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= 32'd0;
      wen_q        <= 1'b0;
      wdata_q      <= 32'd0;
      wmask_q      <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Word array with per-byte write enables. Not reset, so committed writes
  // survive a reset; mem_we_s is low whenever the FSM is held in reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      for (int k = 0; k < 4; k++) begin
        if (wmask_q[k]) begin
          mem_q[idx_s][8*k +: 8] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. Three instances share a clock:
//   inst 0 : LATENCY=2 (main functional tests)
//   inst 1 : LATENCY=4 (reset during an uncommitted write)
//   inst 2 : LATENCY=1 (back-to-back transactions)
// Expected responses are pushed to a scoreboard queue at request acceptance
// and popped when the matching response appears.
module tb_mem_responder;

  logic        clk;
  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [31:0] req_addr   [3];
  logic        req_wen    [3];
  logic [31:0] req_wdata  [3];
  logic [7:0]  req_wmask  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  time  last_acc_t;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
    mem_responder #(
      .ADDR_BASE (32'h8000_0000),
      .DEPTH_LOG2(12),
      .LATENCY   (LAT)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst[g]),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .req_addr_i  (req_addr[g]),
      .req_wen_i   (req_wen[g]),
      .req_wdata_i (req_wdata[g]),
      .req_wmask_i (req_wmask[g]),
      .resp_valid_o(resp_valid[g]),
      .resp_ready_i(resp_ready[g]),
      .resp_rdata_o(resp_rdata[g]),
      .resp_err_o  (resp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One full transaction on instance d with resp_ready held at 1. Called at
  // a negedge; returns at the negedge following the response handshake, so a
  // following call is accepted on the very next edge.
  task automatic do_txn(input int d, input logic [31:0] addr, input logic wen,
                        input logic [31:0] wdata, input logic [7:0] wmask,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input string name);
    exp_t e;
    int   k;
    req_addr[d]   = addr;
    req_wen[d]    = wen;
    req_wdata[d]  = wdata;
    req_wmask[d]  = wmask;
    req_valid[d]  = 1'b1;
    resp_ready[d] = 1'b1;
    k = 0;
    while (req_ready[d] !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s accept: req_ready stuck at %b, expected 1", name, req_ready[d]);
      req_valid[d] = 1'b0;
      return;
    end
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    sb_q.push_back(e);
    @(posedge clk);
    last_acc_t = $time;
    @(negedge clk);
    req_valid[d] = 1'b0;
    // k counts edges after the accept edge seen before this negedge
    k = 0;
    while (resp_valid[d] !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    e = sb_q.pop_front();
    n_cmp++;
    if (k !== e.lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d edges, expected %0d", name, k, e.lat);
    end
    n_cmp++;
    if (resp_rdata[d] !== e.rdata) begin
      n_err++;
      $display("FAIL %s rdata: got %h, expected %h", name, resp_rdata[d], e.rdata);
    end
    n_cmp++;
    if (resp_err[d] !== e.err) begin
      n_err++;
      $display("FAIL %s err: got %b, expected %b", name, resp_err[d], e.err);
    end
    @(negedge clk);
    n_cmp++;
    if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
      n_err++;
      $display("FAIL %s post_handshake: resp_valid=%b req_ready=%b, expected 0/1",
               name, resp_valid[d], req_ready[d]);
    end
  endtask

  task automatic test_reset();
    #12;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (req_ready[d] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_req_ready[%0d]: got %b, expected 1", d, req_ready[d]);
      end
      n_cmp++;
      if (resp_valid[d] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_resp_valid[%0d]: got %b, expected 0", d, resp_valid[d]);
      end
      n_cmp++;
      if (resp_rdata[d] !== 32'h0 || resp_err[d] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_resp_data[%0d]: got %h/%b, expected 0/0", d, resp_rdata[d], resp_err[d]);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
  endtask

  task automatic test_write_read();
    do_txn(0, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 8'h0F, 32'h0, 1'b0, 2, "wr_write");
    do_txn(0, 32'h8000_0010, 1'b0, 32'h0, 8'h00, 32'hDEAD_BEEF, 1'b0, 2, "wr_read");
  endtask

  task automatic test_byte_mask();
    do_txn(0, 32'h8000_0020, 1'b1, 32'h1122_3344, 8'h0F, 32'h0, 1'b0, 2, "bm_full");
    do_txn(0, 32'h8000_0020, 1'b1, 32'hAABB_CCDD, 8'h05, 32'h0, 1'b0, 2, "bm_m05");
    do_txn(0, 32'h8000_0020, 1'b0, 32'h0, 8'h00, 32'h11BB_33DD, 1'b0, 2, "bm_read1");
    do_txn(0, 32'h8000_0020, 1'b1, 32'h0000_0000, 8'hF0, 32'h0, 1'b0, 2, "bm_mF0");
    do_txn(0, 32'h8000_0020, 1'b0, 32'h0, 8'h00, 32'h11BB_33DD, 1'b0, 2, "bm_read2");
  endtask

  // Read held under backpressure with req_valid kept high; a second read is
  // waiting and must be accepted on the edge after the handshake.
  task automatic test_backpressure();
    exp_t e;
    int   k;
    req_addr[0]   = 32'h8000_0010;
    req_wen[0]    = 1'b0;
    req_wdata[0]  = 32'h0;
    req_wmask[0]  = 8'h00;
    req_valid[0]  = 1'b1;
    resp_ready[0] = 1'b0;
    e.rdata = 32'hDEAD_BEEF;
    e.err   = 1'b0;
    e.lat   = 2;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_addr[0] = 32'h8000_0020;
    k = 0;
    while (resp_valid[0] !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    e = sb_q.pop_front();
    n_cmp++;
    if (k !== e.lat) begin
      n_err++;
      $display("FAIL bp_latency: got %0d edges, expected %0d", k, e.lat);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== e.rdata || req_ready[0] !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: valid=%b rdata=%h ready=%b, expected 1/%h/0",
                 i, resp_valid[0], resp_rdata[0], req_ready[0], e.rdata);
      end
      @(negedge clk);
    end
    resp_ready[0] = 1'b1;
    e.rdata = 32'h11BB_33DD;
    e.err   = 1'b0;
    e.lat   = 2;
    sb_q.push_back(e);
    @(negedge clk);
    n_cmp++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      n_err++;
      $display("FAIL bp_handshake: valid=%b ready=%b, expected 0/1", resp_valid[0], req_ready[0]);
    end
    @(negedge clk);
    n_cmp++;
    if (req_ready[0] !== 1'b0) begin
      n_err++;
      $display("FAIL bp_next_accept: req_ready=%b, expected 0", req_ready[0]);
    end
    req_valid[0] = 1'b0;
    k = 0;
    while (resp_valid[0] !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    e = sb_q.pop_front();
    n_cmp++;
    if (k !== e.lat) begin
      n_err++;
      $display("FAIL bp2_latency: got %0d edges, expected %0d", k, e.lat);
    end
    n_cmp++;
    if (resp_rdata[0] !== e.rdata || resp_err[0] !== e.err) begin
      n_err++;
      $display("FAIL bp2_data: got %h/%b, expected %h/%b", resp_rdata[0], resp_err[0], e.rdata, e.err);
    end
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    do_txn(0, 32'h8000_0000, 1'b1, 32'h0000_0000, 8'h0F, 32'h0, 1'b0, 2, "oor_init0");
    do_txn(0, 32'h8000_3FFC, 1'b1, 32'h5A5A_A5A5, 8'h0F, 32'h0, 1'b0, 2, "oor_initlast");
    do_txn(0, 32'h7FFF_FFFC, 1'b0, 32'h0, 8'h00, 32'h0, 1'b1, 2, "oor_read_low");
    do_txn(0, 32'h8000_4000, 1'b1, 32'hFFFF_FFFF, 8'h0F, 32'h0, 1'b1, 2, "oor_write_high");
    do_txn(0, 32'h8000_3FFC, 1'b0, 32'h0, 8'h00, 32'h5A5A_A5A5, 1'b0, 2, "oor_last_word");
    do_txn(0, 32'h8000_0000, 1'b0, 32'h0, 8'h00, 32'h0000_0000, 1'b0, 2, "oor_word0");
  endtask

  task automatic test_unaligned();
    do_txn(0, 32'h8000_0043, 1'b1, 32'hCAFE_F00D, 8'h0F, 32'h0, 1'b0, 2, "ua_write");
    do_txn(0, 32'h8000_0040, 1'b0, 32'h0, 8'h00, 32'hCAFE_F00D, 1'b0, 2, "ua_read");
  endtask

  task automatic test_reset_mid_write();
    do_txn(1, 32'h8000_0100, 1'b1, 32'h0000_0000, 8'h0F, 32'h0, 1'b0, 4, "rmw_clear");
    req_addr[1]   = 32'h8000_0100;
    req_wen[1]    = 1'b1;
    req_wdata[1]  = 32'h1234_5678;
    req_wmask[1]  = 8'h0F;
    req_valid[1]  = 1'b1;
    resp_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    n_cmp++;
    if (req_ready[1] !== 1'b0) begin
      n_err++;
      $display("FAIL rmw_accepted: req_ready=%b, expected 0", req_ready[1]);
    end
    @(posedge clk);
    @(posedge clk);
    #2;
    rst[1] = 1'b1;
    #1;
    n_cmp++;
    if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0) begin
      n_err++;
      $display("FAIL rmw_async: req_ready=%b resp_valid=%b, expected 1/0", req_ready[1], resp_valid[1]);
    end
    n_cmp++;
    if (resp_rdata[1] !== 32'h0 || resp_err[1] !== 1'b0) begin
      n_err++;
      $display("FAIL rmw_outputs: got %h/%b, expected 0/0", resp_rdata[1], resp_err[1]);
    end
    @(negedge clk);
    rst[1] = 1'b0;
    do_txn(1, 32'h8000_0100, 1'b0, 32'h0, 8'h00, 32'h0000_0000, 1'b0, 4, "rmw_read");
  endtask

  // With resp_ready held high: resp_valid rises LAT edges after accept, the
  // handshake takes the next edge and the following accept the one after,
  // so accepts are spaced LAT+2 = 3 cycles apart for LATENCY=1.
  task automatic test_back_to_back();
    time t [4];
    do_txn(2, 32'h8000_0008, 1'b1, 32'h1357_9BDF, 8'h0F, 32'h0, 1'b0, 1, "b2b_wr0");
    t[0] = last_acc_t;
    do_txn(2, 32'h8000_000C, 1'b1, 32'h2468_ACE0, 8'hFF, 32'h0, 1'b0, 1, "b2b_wr1");
    t[1] = last_acc_t;
    do_txn(2, 32'h8000_0008, 1'b0, 32'h0, 8'h00, 32'h1357_9BDF, 1'b0, 1, "b2b_rd0");
    t[2] = last_acc_t;
    do_txn(2, 32'h8000_000C, 1'b0, 32'h0, 8'h00, 32'h2468_ACE0, 1'b0, 1, "b2b_rd1");
    t[3] = last_acc_t;
    for (int i = 1; i < 4; i++) begin
      n_cmp++;
      if ((t[i] - t[i-1]) !== 64'd30) begin
        n_err++;
        $display("FAIL b2b_period[%0d]: got %0t, expected 30", i, t[i] - t[i-1]);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d]        = 1'b1;
      req_valid[d]  = 1'b0;
      req_addr[d]   = 32'h0;
      req_wen[d]    = 1'b0;
      req_wdata[d]  = 32'h0;
      req_wmask[d]  = 8'h00;
      resp_ready[d] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_byte_mask();
    test_backpressure();
    test_out_of_range();
    test_unaligned();
    test_reset_mid_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
